// File: rtl/uart_tx_pkg.sv
// Shared FSM state encoding and parity-type constants for the UART transmit framer.
// The StBreak state exists only when UART_TX_BREAK_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
`ifdef UART_TX_BREAK_EN
    , StBreak
`endif
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Serial bit timer: counts BIT_CYCLES clocks per bit and pulses bit_done_o on the last one.
// restart_i holds the count at zero so the first bit after it gets a full period.
module uart_tx_bit_timer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart_i,
  output logic bit_done_o
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_done_o = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the BREAK_REQ port and line-break generation.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK_REQ,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  restart;
  logic                  bit_done;
  logic                  par_bit;

  uart_tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .CLK       (CLK),
    .RST       (RST),
    .restart_i (restart),
    .bit_done_o(bit_done)
  );

  assign par_bit = (^data_q) ^ (par_typ_q == PAR_ODD);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    restart   = 1'b0;

    case (state_q)
      StIdle: begin
        restart = 1'b1;
`ifdef UART_TX_BREAK_EN
        // Break wins over a simultaneous data request, which is dropped.
        if (BREAK_REQ) begin
          state_d = StBreak;
          stop2_d = 1'b0;
        end else
`endif
        if (DATA_VALID) begin
          state_d   = StStart;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          stop2_d   = STOP2;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          if (idx_q == IdxLast) begin
            state_d = par_en_q ? StParity : StStop1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (bit_done) begin
          state_d = stop2_q ? StStop2 : StIdle;
        end
      end
      StStop2: begin
        if (bit_done) begin
          state_d = StIdle;
        end
      end
`ifdef UART_TX_BREAK_EN
      StBreak: begin
        restart = 1'b1;
        if (!BREAK_REQ) begin
          state_d = StStop1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Line level is registered, so decode it from the state being entered.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_q[idx_d];
      StParity: tx_d = par_bit;
`ifdef UART_TX_BREAK_EN
      StBreak:  tx_d = 1'b0;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      data_q    <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer: one instance at BIT_CYCLES=1, one at 4.
// Expected line levels are hand-written bit strings, one character per serial bit.
module tb_uart_tx_framer;

  logic       CLK;
  logic       RST;
  logic [7:0] p_data;
  logic       dv1, dv4;
  logic       par_en, par_typ, stop2;
  logic       brk1, brk4;
  logic       tx1, busy1, tx4, busy4;

  int tests = 0;
  int fails = 0;

  uart_tx_framer #(
    .DATA_WIDTH(8),
    .BIT_CYCLES(1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (p_data),
    .DATA_VALID(dv1),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .STOP2     (stop2),
`ifdef UART_TX_BREAK_EN
    .BREAK_REQ (brk1),
`endif
    .TX_OUT    (tx1),
    .BUSY      (busy1)
  );

  uart_tx_framer #(
    .DATA_WIDTH(8),
    .BIT_CYCLES(4)
  ) dut4 (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (p_data),
    .DATA_VALID(dv4),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .STOP2     (stop2),
`ifdef UART_TX_BREAK_EN
    .BREAK_REQ (brk4),
`endif
    .TX_OUT    (tx4),
    .BUSY      (busy4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_dv(input bit sel, input logic v);
    if (sel) dv4 = v;
    else dv1 = v;
  endtask

  // Called at a negedge. Each character of exp is held for bc cycles. If inj >= 0, a
  // 0x3C request is pulsed when bit inj starts; it must have no effect.
  task automatic run_frame(input bit sel, input string tag, input logic [7:0] d,
                           input logic pe, input logic pt, input logic s2,
                           input string exp, input int bc, input int inj);
    p_data  = d;
    par_en  = pe;
    par_typ = pt;
    stop2   = s2;
    set_dv(sel, 1'b1);
    @(negedge CLK);
    set_dv(sel, 1'b0);
    for (int i = 0; i < exp.len(); i++) begin
      for (int k = 0; k < bc; k++) begin
        chk($sformatf("%s tx bit%0d cyc%0d", tag, i, k), sel ? tx4 : tx1, exp[i] == 8'h31);
        chk($sformatf("%s busy bit%0d cyc%0d", tag, i, k), sel ? busy4 : busy1, 1'b1);
        if (i == inj && k == 0) begin
          p_data = 8'h3C;
          set_dv(sel, 1'b1);
        end
        @(negedge CLK);
        set_dv(sel, 1'b0);
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s idle busy %0d", tag, j), sel ? busy4 : busy1, 1'b0);
      chk($sformatf("%s idle tx %0d", tag, j), sel ? tx4 : tx1, 1'b1);
      @(negedge CLK);
    end
  endtask

  initial begin
    RST     = 1'b1;
    p_data  = 8'h00;
    dv1     = 1'b0;
    dv4     = 1'b0;
    par_en  = 1'b0;
    par_typ = 1'b0;
    stop2   = 1'b0;
    brk1    = 1'b0;
    brk4    = 1'b0;

    repeat (2) @(negedge CLK);
    chk("reset tx", tx1, 1'b1);
    chk("reset busy", busy1, 1'b0);
    chk("reset tx4", tx4, 1'b1);
    chk("reset busy4", busy4, 1'b0);

    // Request presented on the first edge after reset release.
    RST = 1'b0;
    run_frame(1'b0, "a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, "01010010101", 1, -1);
    run_frame(1'b0, "01_odd", 8'h01, 1'b1, 1'b1, 1'b0, "01000000001", 1, -1);
    run_frame(1'b0, "01_even", 8'h01, 1'b1, 1'b0, 1'b0, "01000000011", 1, -1);
    run_frame(1'b0, "3c_nopar_stop2", 8'h3C, 1'b0, 1'b0, 1'b1, "00011110011", 1, -1);
    run_frame(1'b0, "a5_midframe_req", 8'hA5, 1'b1, 1'b0, 1'b0, "01010010101", 1, 5);
    run_frame(1'b1, "ff_bc4_stop2", 8'hFF, 1'b0, 1'b0, 1'b1, "01111111111", 4, -1);

    // Reset during data bit 3 of 0xA5 (bit value 0).
    p_data  = 8'hA5;
    par_en  = 1'b1;
    par_typ = 1'b0;
    stop2   = 1'b0;
    dv1     = 1'b1;
    @(negedge CLK);
    dv1 = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort pre tx bit3", tx1, 1'b0);
    chk("abort pre busy", busy1, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("abort tx async", tx1, 1'b1);
    chk("abort busy async", busy1, 1'b0);
    @(negedge CLK);
    chk("abort held tx", tx1, 1'b1);
    chk("abort held busy", busy1, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort no resume tx", tx1, 1'b1);
    chk("abort no resume busy", busy1, 1'b0);
    run_frame(1'b0, "after_abort", 8'h01, 1'b1, 1'b1, 1'b0, "01000000001", 1, -1);

`ifdef UART_TX_BREAK_EN
    p_data = 8'h5A;
    brk1   = 1'b1;
    dv1    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk($sformatf("break low %0d", i), tx1, 1'b0);
      chk($sformatf("break busy %0d", i), busy1, 1'b1);
    end
    brk1 = 1'b0;
    dv1  = 1'b0;
    @(negedge CLK);
    chk("break stop tx", tx1, 1'b1);
    chk("break stop busy", busy1, 1'b1);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      chk($sformatf("break idle tx %0d", j), tx1, 1'b1);
      chk($sformatf("break idle busy %0d", j), busy1, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
